processing_array_sched: RTL and testbench

Round-robin scheduler that shares one `processing_array` instance among `NUM_REQ` requesters. It accepts one job at a time through per-requester valid/ready handshakes and drives the job's operand onto the array's broadcast `data_in`. After a fixed array latency it captures the `ARRAY_SIZE`-wide `data_out` vector and returns it with the requester ID over a valid/ready response port. It sits directly in front of the array and is the only agent driving the array input.

---
 rtl/processing_array_sched.sv | 129 ++++++++++++
 tb/tb_processing_array_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/processing_array_sched.sv
// Round-robin front end that shares one processing array among NUM_REQ requesters:
// accepts one job, drives the array input, waits the array latency and returns the result.
module processing_array_sched #(
  parameter int NUM_REQ       = 4,
  parameter int ARRAY_SIZE    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int ARRAY_LATENCY = 2,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic [DATA_WIDTH-1:0]                  arr_data_in,
  input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0]  arr_data_out,
  output logic                                   resp_valid,
  input  logic                                   resp_ready,
  output logic [ID_W-1:0]                        resp_id,
  output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0]  resp_data,
  output logic                                   busy,
  output logic [15:0]                            job_count
);

  localparam int CNT_W = $clog2(ARRAY_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                                state_q, state_d;
  logic [ID_W-1:0]                       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]                 arr_data_in_q, arr_data_in_d;
  logic                                  resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]                       resp_id_q, resp_id_d;
  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [15:0]                           job_count_q, job_count_d;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand_id;

  // Rotating priority search: the requester after the last winner is looked at first.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_id     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_id = ID_W'((int'(last_grant_q) + i) % NUM_REQ);
      if (!grant_found && req_valid[cand_id]) begin
        grant_found = 1'b1;
        grant_idx   = cand_id;
      end
    end
  end

  assign req_ready = (state_q == S_IDLE && grant_found) ? (NUM_REQ'(1) << grant_idx) : '0;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    arr_data_in_d = arr_data_in_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_data_d   = resp_data_q;
    job_count_d   = job_count_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          arr_data_in_d = req_data[grant_idx];
          resp_id_d     = grant_idx;
          last_grant_d  = grant_idx;
          cnt_d         = CNT_W'(ARRAY_LATENCY);
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          resp_data_d  = arr_data_out;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          job_count_d  = job_count_q + 16'd1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; the reset branch is synchronous and overrides any handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      cnt_q         <= '0;
      arr_data_in_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_data_q   <= '0;
      job_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      arr_data_in_q <= arr_data_in_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_data_q   <= resp_data_d;
      job_count_q   <= job_count_d;
    end
  end

  assign arr_data_in = arr_data_in_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_data   = resp_data_q;
  assign job_count   = job_count_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_processing_array_sched.sv
// Directed bench for processing_array_sched with a behavioural array whose
// data_out[k] = data_in + k becomes visible ARRAY_LATENCY edges after the input updates.
module tb_processing_array_sched;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0][7:0]  req_data;
  logic [3:0]       req_ready;
  logic [7:0]       arr_data_in;
  logic [3:0][7:0]  arr_data_out = '0;
  logic             resp_valid;
  logic             resp_ready;
  logic [1:0]       resp_id;
  logic [3:0][7:0]  resp_data;
  logic             busy;
  logic [15:0]      job_count;

  int n_vec = 0;
  int n_err = 0;

  processing_array_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .arr_data_in(arr_data_in), .arr_data_out(arr_data_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  // The scheduler's arr_data_in register is the first pipeline stage; this is the second.
  always @(posedge clk)
    for (int k = 0; k < 4; k++) arr_data_out[k] <= arr_data_in + 8'(k);

  function automatic logic [3:0][7:0] exp_vec(input logic [7:0] op);
    logic [3:0][7:0] v;
    for (int k = 0; k < 4; k++) v[k] = op + 8'(k);
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_data = '0; resp_ready = 1'b0;
    repeat (2) tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    n_vec++; if (arr_data_in !== 8'h00) begin n_err++; $display("FAIL rst_arr_in: got %h want 00", arr_data_in); end
    n_vec++; if (job_count !== 16'h0000) begin n_err++; $display("FAIL rst_job_count: got %h want 0000", job_count); end
    n_vec++; if (resp_id !== 2'd0) begin n_err++; $display("FAIL rst_resp_id: got %0d want 0", resp_id); end
    n_vec++; if (resp_data !== 32'h0) begin n_err++; $display("FAIL rst_resp_data: got %h want 0", resp_data); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    // Reset wins over a coincident accept.
    req_valid = 4'b0001; req_data[0] = 8'h99;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_prio_busy: got %b want 0", busy); end
    n_vec++; if (arr_data_in !== 8'h00) begin n_err++; $display("FAIL rst_prio_arr_in: got %h want 00", arr_data_in); end
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001; req_data[0] = 8'h10; resp_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL single_ready_wait: got %b want 0000", req_ready); end
    n_vec++; if (arr_data_in !== 8'h10) begin n_err++; $display("FAIL single_arr_in: got %h want 10", arr_data_in); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    tick();
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b want 0", resp_valid); end
    tick();
    n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", resp_valid); end
    n_vec++; if (resp_data !== 32'h13121110) begin n_err++; $display("FAIL single_data: got %h want 13121110", resp_data); end
    n_vec++; if (resp_id !== 2'd0) begin n_err++; $display("FAIL single_id: got %0d want 0", resp_id); end
    tick();
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL single_done_valid: got %b want 0", resp_valid); end
    n_vec++; if (job_count !== 16'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", job_count); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", busy); end
  endtask

  task automatic test_fairness();
    logic [1:0] g;
    logic [7:0] op;
    do_reset();
    resp_ready = 1'b1;
    req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      g = 2'(j % 4);
      op = 8'h10 * 8'(j % 4 + 1);
      #1;
      n_vec++; if (req_ready !== (4'b0001 << g)) begin n_err++; $display("FAIL fair_grant%0d: got %b want %b", j, req_ready, 4'b0001 << g); end
      tick();
      n_vec++; if (arr_data_in !== op) begin n_err++; $display("FAIL fair_arr_in%0d: got %h want %h", j, arr_data_in, op); end
      tick(); tick();
      n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL fair_valid%0d: got %b want 1", j, resp_valid); end
      n_vec++; if (resp_id !== g) begin n_err++; $display("FAIL fair_id%0d: got %0d want %0d", j, resp_id, g); end
      n_vec++; if (resp_data !== exp_vec(op)) begin n_err++; $display("FAIL fair_data%0d: got %h want %h", j, resp_data, exp_vec(op)); end
      tick();
      if (j == 4) req_valid = '0;
    end
    n_vec++; if (job_count !== 16'd5) begin n_err++; $display("FAIL fair_count: got %0d want 5", job_count); end
  endtask

  task automatic test_backpressure();
    req_data[2] = 8'h55; req_valid = 4'b0100; resp_ready = 1'b0;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_grant: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b0001;
    tick(); tick();
    for (int c = 0; c < 5; c++) begin
      n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid%0d: got %b want 1", c, resp_valid); end
      n_vec++; if (resp_data !== exp_vec(8'h55)) begin n_err++; $display("FAIL bp_data%0d: got %h want %h", c, resp_data, exp_vec(8'h55)); end
      n_vec++; if (resp_id !== 2'd2) begin n_err++; $display("FAIL bp_id%0d: got %0d want 2", c, resp_id); end
      n_vec++; if (arr_data_in !== 8'h55) begin n_err++; $display("FAIL bp_arr_in%0d: got %h want 55", c, arr_data_in); end
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready%0d: got %b want 0000", c, req_ready); end
      n_vec++; if (job_count !== 16'd5) begin n_err++; $display("FAIL bp_count%0d: got %0d want 5", c, job_count); end
      if (c < 4) tick();
    end
    resp_ready = 1'b1;
    tick();
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b want 0", resp_valid); end
    n_vec++; if (job_count !== 16'd6) begin n_err++; $display("FAIL bp_count_done: got %0d want 6", job_count); end
    n_vec++; if (arr_data_in !== 8'h55) begin n_err++; $display("FAIL bp_hold_arr_in: got %h want 55", arr_data_in); end
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_next_grant: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_job();
    tick();
    req_data[1] = 8'h77; req_valid = 4'b0010; resp_ready = 1'b1;
    tick();
    req_valid = '0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_resp_valid: got %b want 0", resp_valid); end
    n_vec++; if (arr_data_in !== 8'h00) begin n_err++; $display("FAIL mid_arr_in: got %h want 00", arr_data_in); end
    n_vec++; if (job_count !== 16'd0) begin n_err++; $display("FAIL mid_count: got %0d want 0", job_count); end
    tick(); tick();
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_resp: got %b want 0", resp_valid); end
    req_data[0] = 8'h21; req_data[2] = 8'h22; req_valid = 4'b0101;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0100;
    tick(); tick();
    n_vec++; if (resp_id !== 2'd0) begin n_err++; $display("FAIL mid_id0: got %0d want 0", resp_id); end
    n_vec++; if (resp_data !== exp_vec(8'h21)) begin n_err++; $display("FAIL mid_data0: got %h want %h", resp_data, exp_vec(8'h21)); end
    tick();
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL mid_second_grant: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    tick(); tick();
    n_vec++; if (resp_id !== 2'd2) begin n_err++; $display("FAIL mid_id2: got %0d want 2", resp_id); end
    n_vec++; if (resp_data !== exp_vec(8'h22)) begin n_err++; $display("FAIL mid_data2: got %h want %h", resp_data, exp_vec(8'h22)); end
    tick();
  endtask

  task automatic test_withdrawn();
    do_reset();
    resp_ready = 1'b1;
    req_data[0] = 8'h33; req_data[2] = 8'h31; req_data[3] = 8'h32;
    req_valid = 4'b1100;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL wd_first_grant: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b1001;
    tick();
    req_valid = 4'b0001;
    tick();
    n_vec++; if (resp_id !== 2'd2) begin n_err++; $display("FAIL wd_id2: got %0d want 2", resp_id); end
    tick();
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wd_skip3: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    tick(); tick();
    n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL wd_valid: got %b want 1", resp_valid); end
    n_vec++; if (resp_id !== 2'd0) begin n_err++; $display("FAIL wd_id0: got %0d want 0", resp_id); end
    n_vec++; if (resp_data !== exp_vec(8'h33)) begin n_err++; $display("FAIL wd_data: got %h want %h", resp_data, exp_vec(8'h33)); end
    tick();
  endtask

  task automatic test_wrap();
    force dut.job_count_q = 16'hFFFF;
    tick();
    release dut.job_count_q;
    n_vec++; if (job_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preset: got %h want ffff", job_count); end
    req_data[1] = 8'h44; req_valid = 4'b0010; resp_ready = 1'b1;
    tick();
    req_valid = '0;
    tick(); tick();
    n_vec++; if (job_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_pending: got %h want ffff", job_count); end
    tick();
    n_vec++; if (job_count !== 16'h0000) begin n_err++; $display("FAIL wrap_count: got %h want 0000", job_count); end
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL wrap_valid: got %b want 0", resp_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid_job();
    test_withdrawn();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
